// File: rtl/i_decode_pkg.sv
// Shared decode definitions: opcodes, ALUOp encodings and the control bundles latched into ID/EX.
package i_decode_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    wb_ctrl_t wb;
    m_ctrl_t  m;
    ex_ctrl_t ex;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_regfile.sv
// 2-read / 1-write register file with $0 hardwired to zero.
// ID_WB_BYPASS_EN: same-cycle read of the register being written returns the new data.
module id_regfile
  import i_decode_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regs_reg [DEPTH];
  logic [AW-1:0] rd_addr  [2];
  logic [DW-1:0] rd_data  [2];
  logic          wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
    end else if (wr_en) begin
      regs_reg[waddr] <= wdata;
    end
  end

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef ID_WB_BYPASS_EN
      assign rd_data[gi] = (rd_addr[gi] == '0)                  ? '0 :
                           (wr_en && (waddr == rd_addr[gi]))    ? wdata :
                                                                  regs_reg[rd_addr[gi]];
`else
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 : regs_reg[rd_addr[gi]];
`endif
    end
  endgenerate

  assign rs_data = rd_data[0];
  assign rt_data = rd_data[1];

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage: main control decode, register read, sign extension, ID/EX latch.
// Optional macro ID_WB_BYPASS_EN enables write-through in the register file.
module i_decode
  import i_decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       IF_ID_instr,
  input  logic [31:0]       IF_ID_npc,
  input  logic              EX_MEM_PCSrc,
  input  logic              MEM_WB_RegWrite,
  input  logic [REG_AW-1:0] MEM_WB_WriteReg,
  input  logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic [WB_W-1:0]   ID_EX_wb,
  output logic [M_W-1:0]    ID_EX_m,
  output logic [EX_W-1:0]   ID_EX_ex,
  output logic [31:0]       ID_EX_npc,
  output logic [DATA_W-1:0] ID_EX_readdat1,
  output logic [DATA_W-1:0] ID_EX_readdat2,
  output logic [DATA_W-1:0] ID_EX_sign_ext,
  output logic [REG_AW-1:0] ID_EX_instr_2016,
  output logic [REG_AW-1:0] ID_EX_instr_1511
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs_field;
  logic [REG_AW-1:0] rt_field;
  logic [REG_AW-1:0] rd_field;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] sign_ext;
  ctrl_t             ctrl_next;
  ctrl_t             ctrl_reg;

  assign opcode   = IF_ID_instr[31:26];
  assign rs_field = IF_ID_instr[25:21];
  assign rt_field = IF_ID_instr[20:16];
  assign rd_field = IF_ID_instr[15:11];
  assign sign_ext = {{(DATA_W-16){IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  id_regfile #(.DW(DATA_W), .AW(REG_AW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs_addr (rs_field),
    .rt_addr (rt_field),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .we      (MEM_WB_RegWrite),
    .waddr   (MEM_WB_WriteReg),
    .wdata   (MEM_WB_WriteData)
  );

  // Unrecognised opcodes decode to a bubble; a taken branch squashes whatever was decoded.
  always_comb begin
    ctrl_next = CTRL_BUBBLE;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_next.ex.reg_dst  = 1'b1;
        ctrl_next.ex.alu_op   = ALUOP_FUNCT;
        ctrl_next.wb.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_next.ex.alu_op    = ALUOP_ADD;
        ctrl_next.ex.alu_src   = 1'b1;
        ctrl_next.m.mem_read   = 1'b1;
        ctrl_next.wb.reg_write  = 1'b1;
        ctrl_next.wb.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_next.ex.alu_op  = ALUOP_ADD;
        ctrl_next.ex.alu_src = 1'b1;
        ctrl_next.m.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_next.ex.alu_op = ALUOP_SUB;
        ctrl_next.m.branch  = 1'b1;
      end
      default: ctrl_next = CTRL_BUBBLE;
    endcase
    if (EX_MEM_PCSrc) ctrl_next = CTRL_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg         <= CTRL_BUBBLE;
      ID_EX_npc        <= '0;
      ID_EX_readdat1   <= '0;
      ID_EX_readdat2   <= '0;
      ID_EX_sign_ext   <= '0;
      ID_EX_instr_2016 <= '0;
      ID_EX_instr_1511 <= '0;
    end else begin
      ctrl_reg         <= ctrl_next;
      ID_EX_npc        <= IF_ID_npc;
      ID_EX_readdat1   <= rs_data;
      ID_EX_readdat2   <= rt_data;
      ID_EX_sign_ext   <= sign_ext;
      ID_EX_instr_2016 <= rt_field;
      ID_EX_instr_1511 <= rd_field;
    end
  end

  assign ID_EX_wb = ctrl_reg.wb;
  assign ID_EX_m  = ctrl_reg.m;
  assign ID_EX_ex = ctrl_reg.ex;

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: a driver queues expected ID/EX contents, a monitor checks them.
module tb_i_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        EX_MEM_PCSrc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_WB_WriteData;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_m;
  logic [3:0]  ID_EX_ex;
  logic [31:0] ID_EX_npc;
  logic [31:0] ID_EX_readdat1;
  logic [31:0] ID_EX_readdat2;
  logic [31:0] ID_EX_sign_ext;
  logic [4:0]  ID_EX_instr_2016;
  logic [4:0]  ID_EX_instr_1511;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] COLLIDE_RD1 = 32'h22;
`else
  localparam logic [31:0] COLLIDE_RD1 = 32'h11;
`endif

  i_decode dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_instr      (IF_ID_instr),
    .IF_ID_npc        (IF_ID_npc),
    .EX_MEM_PCSrc     (EX_MEM_PCSrc),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_WriteReg  (MEM_WB_WriteReg),
    .MEM_WB_WriteData (MEM_WB_WriteData),
    .ID_EX_wb         (ID_EX_wb),
    .ID_EX_m          (ID_EX_m),
    .ID_EX_ex         (ID_EX_ex),
    .ID_EX_npc        (ID_EX_npc),
    .ID_EX_readdat1   (ID_EX_readdat1),
    .ID_EX_readdat2   (ID_EX_readdat2),
    .ID_EX_sign_ext   (ID_EX_sign_ext),
    .ID_EX_instr_2016 (ID_EX_instr_2016),
    .ID_EX_instr_1511 (ID_EX_instr_1511)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wb"},   {30'd0, ID_EX_wb}, 32'd0);
    check({tag, ".m"},    {29'd0, ID_EX_m},  32'd0);
    check({tag, ".ex"},   {28'd0, ID_EX_ex}, 32'd0);
    check({tag, ".npc"},  ID_EX_npc,      32'd0);
    check({tag, ".rd1"},  ID_EX_readdat1, 32'd0);
    check({tag, ".rd2"},  ID_EX_readdat2, 32'd0);
    check({tag, ".sext"}, ID_EX_sign_ext, 32'd0);
    check({tag, ".rt"},   {27'd0, ID_EX_instr_2016}, 32'd0);
    check({tag, ".rd"},   {27'd0, ID_EX_instr_1511}, 32'd0);
  endtask

  // Drives one decode cycle (with optional write-back) and queues what ID/EX must hold after it.
  task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] npc,
                       input logic pcsrc, input logic we, input logic [4:0] wreg,
                       input logic [31:0] wdata, input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] sext, input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    @(negedge clk);
    IF_ID_instr      = instr;
    IF_ID_npc        = npc;
    EX_MEM_PCSrc     = pcsrc;
    MEM_WB_RegWrite  = we;
    MEM_WB_WriteReg  = wreg;
    MEM_WB_WriteData = wdata;
    e.name = name; e.wb = wb; e.m = m; e.ex = ex; e.npc = npc;
    e.rd1 = rd1; e.rd2 = rd2; e.sext = sext; e.rt = rt; e.rd = rd;
    exp_q.push_back(e);
    $display("issue %-10s instr=0x%08h pcsrc=%0b we=%0b wreg=%0d wdata=0x%08h",
             name, instr, pcsrc, we, wreg, wdata);
  endtask

  task automatic idle();
    @(negedge clk);
    MEM_WB_RegWrite = 1'b0;
    EX_MEM_PCSrc    = 1'b0;
    IF_ID_instr     = 32'hFC00_0000;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".wb"},   {30'd0, ID_EX_wb}, {30'd0, e.wb});
        check({e.name, ".m"},    {29'd0, ID_EX_m},  {29'd0, e.m});
        check({e.name, ".ex"},   {28'd0, ID_EX_ex}, {28'd0, e.ex});
        check({e.name, ".npc"},  ID_EX_npc,      e.npc);
        check({e.name, ".rd1"},  ID_EX_readdat1, e.rd1);
        check({e.name, ".rd2"},  ID_EX_readdat2, e.rd2);
        check({e.name, ".sext"}, ID_EX_sign_ext, e.sext);
        check({e.name, ".rt"},   {27'd0, ID_EX_instr_2016}, {27'd0, e.rt});
        check({e.name, ".rd"},   {27'd0, ID_EX_instr_1511}, {27'd0, e.rd});
        $display("check %-10s wb=%b m=%b ex=%b rd1=0x%08h rd2=0x%08h sext=0x%08h",
                 e.name, ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_readdat1, ID_EX_readdat2,
                 ID_EX_sign_ext);
      end
    end
  end

  initial begin : driver
    rst_n            = 1'b0;
    IF_ID_instr      = 32'h8C22_0004;
    IF_ID_npc        = 32'h0000_0040;
    EX_MEM_PCSrc     = 1'b0;
    MEM_WB_RegWrite  = 1'b0;
    MEM_WB_WriteReg  = 5'd0;
    MEM_WB_WriteData = 32'd0;
    #2;
    check_all_zero("reset0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //      name        instr         npc         pcsrc we  wreg  wdata          wb     m       ex       rd1           rd2           sext          rt     rd
    issue("lw",        32'h8C220004, 32'h104, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 2'b11, 3'b010, 4'b0001, 32'h0,        32'h0,        32'h00000004, 5'd2, 5'd0);
    issue("rd_r5",     32'h00A01820, 32'h108, 1'b0, 1'b1, 5'd0, 32'h00001234, 2'b10, 3'b000, 4'b1100, 32'hDEADBEEF, 32'h0,        32'h00001820, 5'd0, 5'd3);
    issue("rd_r0",     32'h00052020, 32'h10C, 1'b0, 1'b1, 5'd7, 32'h00000011, 2'b10, 3'b000, 4'b1100, 32'h0,        32'hDEADBEEF, 32'h00002020, 5'd5, 5'd4);
    issue("collide",   32'h00E54020, 32'h110, 1'b0, 1'b1, 5'd7, 32'h00000022, 2'b10, 3'b000, 4'b1100, COLLIDE_RD1,  32'hDEADBEEF, 32'h00004020, 5'd5, 5'd8);
    issue("sw",        32'hAC078000, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0,        2'b00, 3'b001, 4'b0001, 32'h0,        32'h00000022, 32'hFFFF8000, 5'd7, 5'd16);
    issue("beq_flush", 32'h10220003, 32'h118, 1'b1, 1'b1, 5'd9, 32'h00000099, 2'b00, 3'b000, 4'b0000, 32'h0,        32'h0,        32'h00000003, 5'd2, 5'd0);
    issue("beq",       32'h10228000, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0,        2'b00, 3'b100, 4'b0010, 32'h0,        32'h0,        32'hFFFF8000, 5'd2, 5'd16);
    issue("jump_op",   32'h08000010, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0,        2'b00, 3'b000, 4'b0000, 32'h0,        32'h0,        32'h00000010, 5'd0, 5'd0);
    issue("rd_r9",     32'h01205020, 32'h124, 1'b0, 1'b0, 5'd0, 32'h0,        2'b10, 3'b000, 4'b1100, 32'h00000099, 32'h0,        32'h00005020, 5'd0, 5'd10);
    idle();
    repeat (2) @(negedge clk);

    // Mid-run reset: outputs must clear without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst",  32'h00A71820, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0,        2'b10, 3'b000, 4'b1100, 32'h0,        32'h0,        32'h00001820, 5'd7, 5'd3);
    idle();
    repeat (3) @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
